// File: rtl/babbage_pkg.sv
// ============================================================================
// Module  : babbage_pkg
// Brief   : Shared states, types and helpers for the difference engine.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package babbage_pkg;

    localparam int MAX_ORDER         = 6;
    localparam int DEFAULT_OUT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [DEFAULT_OUT_WIDTH-1:0] diff_t;

    // Largest evaluation point (and iteration count) reachable with a given n width.
    function automatic int max_n(input int in_width);
        return (1 << in_width) - 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/babbage_diff_column.sv
// ============================================================================
// Module  : babbage_diff_column
// Brief   : One difference register with its adder: loads an initial value,
//           or accumulates the next-higher difference on each step.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module babbage_diff_column #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_init,
    input  logic [WIDTH-1:0] i_addend,
    output logic [WIDTH-1:0] o_q,
    output logic             o_carry
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH:0]   w_sum;

    assign w_sum = {1'b0, r_q} + {1'b0, i_addend};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_init;
        end else if (i_step) begin
            r_q <= w_sum[WIDTH-1:0];
        end
    end

    assign o_q     = r_q;
    assign o_carry = w_sum[WIDTH];

endmodule

`default_nettype wire

// File: rtl/babbage_poly_engine.sv
// ============================================================================
// Module  : babbage_poly_engine
// Brief   : Difference engine evaluating a degree-ORDER polynomial at n using
//           additions only. Optional macro BABBAGE_STREAM_EN adds f_valid and
//           f_stream, which emit f(0)..f(n) during RUN.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module babbage_poly_engine
    import babbage_pkg::*;
#(
    parameter int IN_WIDTH  = 5,
    parameter int OUT_WIDTH = 16,
    parameter int ORDER     = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [IN_WIDTH-1:0]             n,
    input  logic [ORDER:0][OUT_WIDTH-1:0]   d_init,
    output logic [OUT_WIDTH-1:0]            f_out,
    output logic                            done,
    output logic                            rdy,
    output logic                            ovf
`ifdef BABBAGE_STREAM_EN
    ,
    output logic                            f_valid,
    output logic [OUT_WIDTH-1:0]            f_stream
`endif
);

    state_t                r_state;
    state_t                w_state_next;
    logic [IN_WIDTH-1:0]   r_cnt;
    logic                  r_ovf_acc;
    logic [OUT_WIDTH-1:0]  r_top;
    logic [OUT_WIDTH-1:0]  w_reg [0:ORDER];
    logic [ORDER-1:0]      w_carry;
    logic                  w_load;
    logic                  w_step;

    assign w_load = rdy && start;
    assign w_step = (r_state == RUN) && (r_cnt != '0);

    // Column i adds column i+1; all columns update together from old values.
    for (genvar gi = 0; gi < ORDER; gi++) begin : g_col
        babbage_diff_column #(
            .WIDTH(OUT_WIDTH)
        ) u_col (
            .clk      (clk),
            .rst      (rst),
            .i_load   (w_load),
            .i_step   (w_step),
            .i_init   (d_init[gi]),
            .i_addend (w_reg[gi+1]),
            .o_q      (w_reg[gi]),
            .o_carry  (w_carry[gi])
        );
    end

    // Highest difference of a degree-ORDER polynomial is constant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_top <= '0;
        end else if (w_load) begin
            r_top <= d_init[ORDER];
        end
    end

    assign w_reg[ORDER] = r_top;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_ovf_acc <= 1'b0;
        end else if (w_load) begin
            r_cnt     <= n;
            r_ovf_acc <= 1'b0;
        end else if (w_step) begin
            r_cnt     <= r_cnt - 1'b1;
            r_ovf_acc <= r_ovf_acc | (|w_carry);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        rdy          = 1'b0;
        case (r_state)
            IDLE: begin
                rdy = 1'b1;
                if (start) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (r_cnt == '0) begin
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Result, flag and pulse are registered together on leaving DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            f_out <= '0;
            done  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (r_state == DONE) begin
                done  <= 1'b1;
                f_out <= w_reg[0];
                ovf   <= r_ovf_acc;
            end
        end
    end

`ifdef BABBAGE_STREAM_EN
    assign f_valid  = (r_state == RUN);
    assign f_stream = f_valid ? w_reg[0] : '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_babbage_poly_engine.sv
// ============================================================================
// Module  : tb_babbage_poly_engine
// Brief   : Directed vector table plus corner sequences for babbage_poly_engine.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_babbage_poly_engine;
    import babbage_pkg::*;

    localparam int IW  = 5;
    localparam int OW  = 16;
    localparam int ORD = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic [IW-1:0]           n;
    logic [ORD:0][OW-1:0]    d_init;
    logic [OW-1:0]           f_out;
    logic                    done;
    logic                    rdy;
    logic                    ovf;
`ifdef BABBAGE_STREAM_EN
    logic                    f_valid;
    logic [OW-1:0]           f_stream;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    babbage_poly_engine #(
        .IN_WIDTH  (IW),
        .OUT_WIDTH (OW),
        .ORDER     (ORD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .n        (n),
        .d_init   (d_init),
        .f_out    (f_out),
        .done     (done),
        .rdy      (rdy),
        .ovf      (ovf)
`ifdef BABBAGE_STREAM_EN
        ,
        .f_valid  (f_valid),
        .f_stream (f_stream)
`endif
    );

    typedef struct {
        logic [IW-1:0] nn;
        logic [OW-1:0] a;
        logic [OW-1:0] b;
        logic [OW-1:0] c;
        logic [OW-1:0] f;
        logic          v;
    } vec_t;

    vec_t tv [10];

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Newton forward form: f(k) = a + C(k,1)*b + C(k,2)*c, mod 2^OW.
    function automatic logic [OW-1:0] model(input int k, input logic [OW-1:0] a,
                                            input logic [OW-1:0] b, input logic [OW-1:0] c);
        longint s;
        s = longint'(a) + longint'(k) * longint'(b) + (longint'(k) * longint'(k - 1) / 2) * longint'(c);
        return s[OW-1:0];
    endfunction

    // Called at a falling edge; returns at the falling edge where done is seen.
    task automatic run(input logic [IW-1:0] nn, input logic [OW-1:0] a, input logic [OW-1:0] b,
                       input logic [OW-1:0] c, input bit poke,
                       output logic [OW-1:0] rf, output logic rovf, output int lat);
        logic [OW-1:0] f_before;
        bit            hold_ok;
        int            beats;
        hold_ok = 1'b1;
        beats   = 0;
        chk("rdy_at_start", rdy, 1);
        start    = 1'b1;
        n        = nn;
        d_init   = {c, b, a};
        f_before = f_out;
        @(negedge clk);
        start  = 1'b0;
        n      = IW'($urandom);
        d_init = {OW'($urandom), OW'($urandom), OW'($urandom)};
        lat    = 0;
        forever begin
`ifdef BABBAGE_STREAM_EN
            if (f_valid) begin
                chk("stream_beat", f_stream, model(beats, a, b, c));
                beats++;
            end
`endif
            if (done) break;
            if (f_out !== f_before) hold_ok = 1'b0;
            if (poke && lat == 2) begin
                chk("rdy_low_in_run", rdy, 0);
                start  = 1'b1;
                n      = 5'd1;
                d_init = {16'd9, 16'd9, 16'd9};
            end
            if (poke && lat == 3) start = 1'b0;
            if (lat >= 100) begin
                n_cmp++;
                n_bad++;
                $display("FAIL done_timeout: got no done expected done within 100 cycles");
                break;
            end
            @(negedge clk);
            lat++;
        end
        chk("f_hold_in_run", hold_ok, 1);
`ifdef BABBAGE_STREAM_EN
        chk("stream_beats", beats, int'(nn) + 1);
`endif
        rf   = f_out;
        rovf = ovf;
    endtask

    initial begin
        logic [OW-1:0] rf;
        logic          rovf;
        int            lat;
        bit            saw;
        logic [IW-1:0] rn;
        logic [OW-1:0] ra, rb, rc;

        tv[0] = '{5'd2,  16'd5,     16'd5,     16'd4, 16'd19,    1'b0};
        tv[1] = '{5'd3,  16'd5,     16'd5,     16'd4, 16'd32,    1'b0};
        tv[2] = '{5'd0,  16'd5,     16'd5,     16'd4, 16'd5,     1'b0};
        tv[3] = '{5'd31, 16'd5,     16'd5,     16'd4, 16'd2020,  1'b0};
        tv[4] = '{5'd1,  16'd65530, 16'd10,    16'd0, 16'd4,     1'b1};
        tv[5] = '{5'd3,  16'd1,     16'd1,     16'd0, 16'd4,     1'b0};
        tv[6] = '{5'd1,  16'd0,     16'd65535, 16'd1, 16'd65535, 1'b1};
        tv[7] = '{5'd5,  16'd100,   16'd65535, 16'd0, 16'd95,    1'b1};
        tv[8] = '{5'd10, 16'd7,     16'd0,     16'd0, 16'd7,     1'b0};
        tv[9] = '{5'd4,  16'd0,     16'd0,     16'd2, 16'd12,    1'b0};

        rst    = 1'b1;
        start  = 1'b0;
        n      = '0;
        d_init = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_rdy",   rdy,   1);
        chk("reset_done",  done,  0);
        chk("reset_f_out", f_out, 0);
        chk("reset_ovf",   ovf,   0);
        @(negedge clk);

        // Each run starts in the done cycle of the previous one.
        for (int i = 0; i < 10; i++) begin
            run(tv[i].nn, tv[i].a, tv[i].b, tv[i].c, 1'b0, rf, rovf, lat);
            chk($sformatf("vec%0d_f", i),   rf,   tv[i].f);
            chk($sformatf("vec%0d_ovf", i), rovf, tv[i].v);
            chk($sformatf("vec%0d_lat", i), lat,  int'(tv[i].nn) + 2);
        end

        @(negedge clk);
        chk("done_one_cycle", done, 0);

        run(5'd5, 16'd5, 16'd5, 16'd4, 1'b1, rf, rovf, lat);
        chk("poke_f",   rf,  70);
        chk("poke_lat", lat, 7);
        @(negedge clk);
        chk("poke_not_queued_rdy", rdy, 1);
        @(negedge clk);
        chk("poke_not_queued_rdy2", rdy, 1);

        start  = 1'b1;
        n      = 5'd20;
        d_init = {16'd4, 16'd5, 16'd5};
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_rdy",   rdy,   1);
        chk("abort_f_out", f_out, 0);
        chk("abort_done",  done,  0);
        saw = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (done) saw = 1'b1;
        end
        chk("abort_no_done", saw, 0);
        run(5'd3, 16'd5, 16'd5, 16'd4, 1'b0, rf, rovf, lat);
        chk("after_abort_f", rf, 32);

        for (int i = 0; i < 20; i++) begin
            rn = IW'($urandom_range(0, max_n(IW)));
            ra = OW'($urandom);
            rb = OW'($urandom);
            rc = OW'($urandom);
            run(rn, ra, rb, rc, 1'b0, rf, rovf, lat);
            chk($sformatf("rand%0d_f", i), rf, model(int'(rn), ra, rb, rc));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
